// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between NUM_REQ requesters.
//
// One operation is in flight at a time. The block grants a requester while
// IDLE and registers that requester's operands. It then drives the shared
// ALU for ALU_LATENCY+1 cycles and captures the result. Finally it presents
// the result, tagged with the requester index, until the consumer takes it.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> the lowest-indexed valid requester always wins
//                          undefined -> round-robin starting after the last grant
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid / req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_opa/req_opb/req_opcode packed per-requester payload, requester i at [i*W +: W]
//   alu_opa/alu_opb/alu_opcode operands to the shared ALU (held between operations)
//   alu_res                   result returned by the shared ALU
//   rsp_valid / rsp_ready     result handshake
//   rsp_id, rsp_data          granted requester index and captured result
//   busy                      high whenever an operation is in progress
module alu_arbiter #(
    parameter int DATA_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 2,
    parameter int NUM_REQ      = 4,
    parameter int ID_WIDTH     = 2,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode,
    output logic [DATA_WIDTH-1:0]        alu_opa,
    output logic [DATA_WIDTH-1:0]        alu_opb,
    output logic [OPCODE_WIDTH-1:0]      alu_opcode,
    input  logic [DATA_WIDTH-1:0]        alu_res,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] LAT_C = 2'(ALU_LATENCY);

    state_t                  state_r;
    logic [1:0]              cnt_r;
    logic [DATA_WIDTH-1:0]   alu_opa_r;
    logic [DATA_WIDTH-1:0]   alu_opb_r;
    logic [OPCODE_WIDTH-1:0] alu_opcode_r;
    logic                    rsp_valid_r;
    logic [ID_WIDTH-1:0]     rsp_id_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic                    busy_r;

    logic [ID_WIDTH-1:0]     grant_s;
    logic                    any_s;

    // Per-requester views of the packed payload buses
    logic [DATA_WIDTH-1:0]   opa_arr_s    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   opb_arr_s    [NUM_REQ];
    logic [OPCODE_WIDTH-1:0] opcode_arr_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign opa_arr_s[i]    = req_opa[i*DATA_WIDTH +: DATA_WIDTH];
        assign opb_arr_s[i]    = req_opb[i*DATA_WIDTH +: DATA_WIDTH];
        assign opcode_arr_s[i] = req_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning from the top down lets the lowest valid index win
    always_comb begin
        grant_s = '0;
        any_s   = |req_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            grant_s = req_valid[k] ? ID_WIDTH'(k) : grant_s;
        end
    end
`else
    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

    logic [ID_WIDTH-1:0] last_grant_r;
    logic [ID_WIDTH:0]   cand_s;
    logic                hit_s;
    logic                found_s;

    // Round-robin: first valid requester at last_grant+1, +2, ... modulo NUM_REQ
    always_comb begin
        grant_s = '0;
        any_s   = |req_valid;
        cand_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s  = {1'b0, last_grant_r} + (ID_WIDTH + 1)'(k);
            cand_s  = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
            hit_s   = req_valid[cand_s[ID_WIDTH-1:0]] & ~found_s;
            grant_s = hit_s ? cand_s[ID_WIDTH-1:0] : grant_s;
            found_s = found_s | hit_s;
        end
    end
`endif

    // Grant is offered only while idle; reset suppresses any handshake that cycle
    always_comb begin
        req_ready = '0;
        if ((state_r == IDLE) && any_s && !rst) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Sequencer: grant in IDLE, wait out the ALU pipeline in EXEC, hold the result in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            alu_opa_r    <= '0;
            alu_opb_r    <= '0;
            alu_opcode_r <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_data_r   <= '0;
            busy_r       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_r <= ID_WIDTH'(NUM_REQ - 1);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        // The operand registers drive the ALU directly, so they
                        // stay put until the next grant.
                        alu_opa_r    <= opa_arr_s[grant_s];
                        alu_opb_r    <= opb_arr_s[grant_s];
                        alu_opcode_r <= opcode_arr_s[grant_s];
                        rsp_id_r     <= grant_s;
                        cnt_r        <= 2'd0;
                        busy_r       <= 1'b1;
                        state_r      <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_r <= grant_s;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_r == LAT_C) begin
                        rsp_data_r  <= alu_res;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 2'd0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cnt_r       <= 2'd0;
                end
            endcase
        end
    end

    assign alu_opa    = alu_opa_r;
    assign alu_opb    = alu_opb_r;
    assign alu_opcode = alu_opcode_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with an adder ALU stub.
// A predictor tracks which requester should win each idle cycle. It pushes
// the expected response into a queue. A monitor compares every presented
// response against the head of that queue.
module tb_alu_arbiter;

    localparam int DATA_WIDTH   = 3;
    localparam int OPCODE_WIDTH = 2;
    localparam int NUM_REQ      = 4;
    localparam int ID_WIDTH     = 2;
    localparam int ALU_LATENCY  = 1;
    localparam int RSP_LAT      = ALU_LATENCY + 2;

    logic                             clk;
    logic                             rst;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_opa;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_opb;
    logic [NUM_REQ*OPCODE_WIDTH-1:0]  req_opcode;
    logic [DATA_WIDTH-1:0]            alu_opa;
    logic [DATA_WIDTH-1:0]            alu_opb;
    logic [OPCODE_WIDTH-1:0]          alu_opcode;
    logic [DATA_WIDTH-1:0]            alu_res = '0;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [ID_WIDTH-1:0]              rsp_id;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic                             busy;

    alu_arbiter #(
        .DATA_WIDTH(DATA_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH), .NUM_REQ(NUM_REQ),
        .ID_WIDTH(ID_WIDTH), .ALU_LATENCY(ALU_LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_opcode(req_opcode),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_opcode(alu_opcode),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered adder stub, one cycle of latency, opcode ignored
    always @(posedge clk) alu_res <= alu_opa + alu_opb;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int data;
        int op;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   m_busy = 1'b0;
    int   m_due  = 0;
    int   m_last = NUM_REQ - 1;
    bit   front_seen = 1'b0;

    // Arbitration rule evaluated from the requester set alone
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
        return -1;
    endfunction

    // Predictor: expected grant, busy and response entries
    always @(negedge clk) begin
        int g;
        int a;
        int b;
        int op;
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_last = NUM_REQ - 1;
            sb.delete();
        end else begin
            chk("busy", int'(busy), int'(m_busy));
            g = m_busy ? -1 : pick(req_valid, m_last);
            chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            if (g >= 0) begin
                a  = int'(req_opa[g*DATA_WIDTH +: DATA_WIDTH]);
                b  = int'(req_opb[g*DATA_WIDTH +: DATA_WIDTH]);
                op = int'(req_opcode[g*OPCODE_WIDTH +: OPCODE_WIDTH]);
                sb.push_back('{g, (a + b) % 8, op, cyc + RSP_LAT});
                m_busy = 1'b1;
                m_due  = cyc + RSP_LAT;
                m_last = g;
            end else if (m_busy && cyc >= m_due && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: compares each presented response with the scoreboard head
    always @(negedge clk) begin
        #2;
        if (rst) begin
            front_seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", int'(rsp_id), sb[0].id);
                chk("rsp_data", int'(rsp_data), sb[0].data);
                chk("alu_opcode", int'(alu_opcode), sb[0].op);
                if (!front_seen) begin
                    chk("rsp_latency", cyc, sb[0].due);
                    front_seen = 1'b1;
                end
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    front_seen = 1'b0;
                end
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            chk("rsp_missing", 0, 1);
        end
    end

    logic [NUM_REQ-1:0] hs;

    // Advance one clock; hs holds the request handshakes taken at that edge
    task automatic tick();
        @(negedge clk);
        hs = req_valid & req_ready & {NUM_REQ{~rst}};
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input int a, input int b);
        req_opa[i*DATA_WIDTH +: DATA_WIDTH]       = DATA_WIDTH'(a);
        req_opb[i*DATA_WIDTH +: DATA_WIDTH]       = DATA_WIDTH'(b);
        req_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = OPCODE_WIDTH'($urandom_range(0, 3));
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_grant(input int i, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            tick();
            got = hs[i];
        end
        chk("grant_seen", int'(got), 1);
    endtask

    task automatic check_reset_values();
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_alu_opa", int'(alu_opa), 0);
        chk("rst_alu_opb", int'(alu_opb), 0);
        chk("rst_alu_opcode", int'(alu_opcode), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_opa    = '0;
        req_opb    = '0;
        req_opcode = '0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values();

        // Single request from requester 0: 3 + 2
        load(0, 3, 2);
        wait_grant(0, 5);
        req_valid[0] = 1'b0;
        repeat (5) tick();

        // All four requesters held together
        for (int i = 0; i < NUM_REQ; i++) load(i, $urandom_range(0, 7), $urandom_range(0, 7));
        for (int n = 0; n < 24; n++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) load(i, $urandom_range(0, 7), $urandom_range(0, 7));
        end
        req_valid = '0;
        repeat (6) tick();

        // Back-pressure on 7 + 7 with another requester waiting
        rsp_ready = 1'b0;
        load(1, 7, 7);
        wait_grant(1, 5);
        req_valid[1] = 1'b0;
        load(2, 4, 1);
        repeat (8) tick();
        rsp_ready = 1'b1;
        wait_grant(2, 5);
        req_valid[2] = 1'b0;
        repeat (5) tick();

        // Reset during EXEC discards the in-flight operation
        load(0, 5, 1);
        wait_grant(0, 5);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values();
        load(0, 2, 2);
        load(3, 6, 3);
        wait_grant(0, 5);
        req_valid[0] = 1'b0;
        wait_grant(3, 8);
        req_valid[3] = 1'b0;
        repeat (5) tick();

        // Wrap-around after a grant to the highest index
        load(3, 1, 1);
        wait_grant(3, 5);
        req_valid[3] = 1'b0;
        repeat (4) tick();
        load(0, 4, 4);
        load(3, 5, 5);
        wait_grant(0, 8);
        req_valid[0] = 1'b0;
        wait_grant(3, 8);
        req_valid[3] = 1'b0;
        repeat (5) tick();

        // Random traffic with random back-pressure and occasional reset
        for (int n = 0; n < 600; n++) begin
            tick();
            rst = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else load(i, $urandom_range(0, 7), $urandom_range(0, 7));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 9) < 3) load(i, $urandom_range(0, 7), $urandom_range(0, 7));
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
        end

        // Drain everything still in flight
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one registered ALU instance between NUM_REQ requesters. Each requester hands over an operand/opcode triple with a valid/ready handshake. The block drives the shared ALU, waits the ALU pipeline latency, and returns the result tagged with the requester index. It sits between the control logic issuing operations and the ALU plus seven-segment display path, and allows one operation in flight at a time.

## Interface
- DATA_WIDTH, 3: operand and result width.
- OPCODE_WIDTH, 2: opcode width.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_WIDTH, 2: requester index width, equal to clog2(NUM_REQ).
- ALU_LATENCY, 1: clock edges from operands presented to alu_res valid, 0..3.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_opa  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_opb  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- req_opcode  in  NUM_REQ*OPCODE_WIDTH  packed opcode.
- alu_opa, alu_opb  out  DATA_WIDTH  operands to the shared ALU.
- alu_opcode  out  OPCODE_WIDTH  opcode to the shared ALU.
- alu_res  in  DATA_WIDTH  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_WIDTH  index of the granted requester.
- rsp_data  out  DATA_WIDTH  captured result.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE transitions:
  - With any req_valid high, the arbiter selects grant g.
  - req_ready[g]=1 combinationally in that cycle only.
  - Operands, opcode and g are registered at the clock edge.
  - Next state is EXEC.
- req_ready is all-zero in EXEC and RESP.
- Round-robin rule:
  - Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 has first priority.
- EXEC transitions:
  - alu_opa, alu_opb and alu_opcode are driven from the operand registers, stable for the whole state.
  - A counter runs 0..ALU_LATENCY.
  - On the edge where the count equals ALU_LATENCY, alu_res is captured into rsp_data.
  - Next state is RESP.
- RESP transitions:
  - rsp_valid=1; rsp_id and rsp_data are held stable.
  - On rsp_valid && rsp_ready, the next state is IDLE.
- ALU operand outputs keep their last values in IDLE and RESP.
- No width conversion: the result is passed through unmodified.
- A request deasserted before its grant is simply not served. A requester must hold its payload only until its ready handshake.

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, alu_opa/alu_opb/alu_opcode 0, busy 0, counter 0.
- Latency, accept to rsp_valid, is ALU_LATENCY+2 edges:
  - Cycle 0: handshake.
  - Cycles 1..ALU_LATENCY+1: EXEC.
  - Cycle ALU_LATENCY+2: rsp_valid rises.
- Minimum issue interval is ALU_LATENCY+3 cycles, because rsp_ready is already high on the first RESP cycle and IDLE grants in the next cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid and are served in round-robin order.
- Back-pressure: rsp_ready low holds RESP indefinitely, with no new grants.
- rst mid-EXEC or mid-RESP:
  - Next edge returns to IDLE with all reset values.
  - The in-flight result is discarded, and no rsp_valid is produced for it.
- rst has priority over all handshakes in the same cycle.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest set req_valid index always wins and last_grant is unused.
- ALU_ARB_FIXED_PRIO_EN undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
The bench ALU stub registers OPA+OPB mod 8, so ALU_LATENCY=1 and the opcode is ignored.
- Single request: req_valid=0001, opa=3, opb=2 -> req_ready=0001 that cycle; rsp_valid 3 cycles later with rsp_id=0, rsp_data=5; busy high for those 3 cycles.
- Four requests held together, round-robin build -> grants in order 0,1,2,3,0. With rsp_ready tied high, consecutive grants are 4 cycles apart.
- Same stimulus with ALU_ARB_FIXED_PRIO_EN defined -> requester 0 is granted every time; requester 3 is never granted while 0 is held.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP with opa=7, opb=7 -> rsp_valid and rsp_data=6 held stable, req_ready stays 0. After rsp_ready=1, the next grant comes one cycle later.
- rst=1 for one cycle during EXEC -> next cycle all outputs are 0, with no response for that request. Requester 0 re-request is granted first (last_grant reset).
- Wrap-around: last grant=3, req_valid=1001 -> grant 0, then grant 3.
